// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: accepts bytes over valid/ready, buffers one byte,
// computes parity and drives the PISO load/shift strobes for one frame per byte.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PARITY_ODD = 0,
  parameter int STOP_GAP   = 0
) (
  input  logic                  baud_rate_tx,
  input  logic                  rst,
  input  logic                  tx_en,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  load,
  output logic                  shift,
  output logic [DATA_WIDTH-1:0] p_data_out,
  output logic                  parity_bit,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int FRAME_BITS = DATA_WIDTH + 3;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int GAP_W      = 4;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_BITS - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = (STOP_GAP > 0) ? GAP_W'(STOP_GAP - 1) : {GAP_W{1'b0}};
  localparam logic ODD_BIT = (PARITY_ODD != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  function automatic logic frame_parity(input logic [DATA_WIDTH-1:0] b);
    return (^b) ^ ODD_BIT;
  endfunction

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  parity_q, parity_d;
  logic                  load_q, load_d;
  logic                  shift_q, shift_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic                  accept_s;
  logic                  go_s;
  logic                  start_s;

  // in_ready follows the registered hold flag, so the entry freed at the frame end is never overwritten
  assign in_ready = !hold_full_q && !rst;
  assign accept_s = in_valid && in_ready;
  assign go_s     = tx_en && (hold_full_q || accept_s);

  // Next-state logic: frame sequencing and bit/gap counters
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    start_s = 1'b0;
    case (state_q)
      IDLE: begin
        if (go_s) begin
          state_d = LOAD;
          start_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        state_d = SHIFT;
        cnt_d   = {CNT_W{1'b0}};
      end
      SHIFT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          if (STOP_GAP > 0) begin
            state_d = GAP;
            gap_d   = {GAP_W{1'b0}};
          end else if (go_s) begin
            state_d = LOAD;
            start_s = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = SHIFT;
        end
      end
      GAP: begin
        gap_d = gap_q + GAP_W'(1);
        if (gap_q == GAP_LAST) begin
          if (go_s) begin
            state_d = LOAD;
            start_s = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = GAP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: hold register fill/drain and active register capture on entry to LOAD
  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    data_d      = data_q;
    parity_d    = parity_q;
    if (start_s) begin
      if (hold_full_q) begin
        data_d      = hold_q;
        hold_full_d = 1'b0;
      end else begin
        data_d = in_data;
      end
      parity_d = frame_parity(data_d);
    end else begin
      data_d = data_q;
    end
    // A byte that starts a frame directly bypasses the hold register
    if (accept_s && !(start_s && !hold_full_q)) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end else begin
      hold_d = hold_q;
    end
  end

  // Output decode from the next state so strobes come straight from flops
  always_comb begin
    load_d       = (state_d == LOAD);
    shift_d      = (state_d == SHIFT);
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == SHIFT) && (cnt_d == CNT_LAST);
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge baud_rate_tx) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= {CNT_W{1'b0}};
      gap_q        <= {GAP_W{1'b0}};
      hold_q       <= {DATA_WIDTH{1'b0}};
      hold_full_q  <= 1'b0;
      data_q       <= {DATA_WIDTH{1'b0}};
      parity_q     <= 1'b0;
      load_q       <= 1'b0;
      shift_q      <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      data_q       <= data_d;
      parity_q     <= parity_d;
      load_q       <= load_d;
      shift_q      <= shift_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign load       = load_q;
  assign shift      = shift_q;
  assign p_data_out = data_q;
  assign parity_bit = parity_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: one default instance plus one with odd parity and a 3-cycle stop gap.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_en;
  logic       in_valid;
  logic [7:0] in_data;

  logic       rdy0, load0, shift0, par0, busy0, done0;
  logic [7:0] data0;
  logic       rdy1, load1, shift1, par1, busy1, done1;
  logic [7:0] data1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl u_dut (
    .baud_rate_tx(clk), .rst(rst), .tx_en(tx_en), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy0), .load(load0), .shift(shift0), .p_data_out(data0),
    .parity_bit(par0), .busy(busy0), .frame_done(done0)
  );

  uart_tx_ctrl #(.DATA_WIDTH(8), .PARITY_ODD(1), .STOP_GAP(3)) u_dut_gap (
    .baud_rate_tx(clk), .rst(rst), .tx_en(tx_en), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy1), .load(load1), .shift(shift1), .p_data_out(data1),
    .parity_bit(par1), .busy(busy1), .frame_done(done1)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic flush(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  // Source keeps in_valid high with 01, 02, 03, advancing on the selected instance's handshake
  task automatic run_stream(input logic sel, input int acc3, input int ld2, input int ld3);
    int   idx;
    int   nld;
    logic acc;
    idx      = 0;
    nld      = 0;
    in_valid = 1'b1;
    in_data  = 8'h01;
    for (int c = 0; c <= ld3 + 12; c++) begin
      @(negedge clk);
      acc = in_valid && (sel ? rdy1 : rdy0);
      check_eq("stream_accept", 32'(acc), 32'(c == 0 || c == 1 || c == acc3));
      check_eq("stream_load", 32'(sel ? load1 : load0), 32'(c == 1 || c == ld2 || c == ld3));
      check_eq("stream_done", 32'(sel ? done1 : done0),
               32'(c == 12 || c == ld2 + 11 || c == ld3 + 11));
      if (sel ? load1 : load0) begin
        nld++;
        check_eq("stream_data", 32'(sel ? data1 : data0), 32'(nld));
      end
      next_cycle();
      if (acc) begin
        idx++;
        if (idx == 3) in_valid = 1'b0;
        else in_data = 8'(idx + 1);
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    tx_en    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    for (int i = 0; i < 3; i++) next_cycle();

    // Reset state
    @(negedge clk);
    check_eq("rst_ready", 32'(rdy0), 32'd0);
    check_eq("rst_ctrl", 32'({load0, shift0, busy0, done0}), 32'd0);
    check_eq("rst_data", 32'({par0, data0}), 32'd0);

    // Single byte A5, even parity on u_dut, odd on u_dut_gap
    next_cycle();
    rst      = 1'b0;
    tx_en    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    for (int c = 0; c <= 13; c++) begin
      @(negedge clk);
      if (c == 0) check_eq("a5_ready", 32'(rdy0), 32'd1);
      check_eq("a5_ctrl", 32'({load0, shift0, done0, busy0}),
               32'({c == 1, c >= 2 && c <= 12, c == 12, c >= 1 && c <= 12}));
      if (c == 1) begin
        check_eq("a5_data", 32'(data0), 32'hA5);
        check_eq("a5_par_even", 32'(par0), 32'd0);
        check_eq("a5_par_odd", 32'(par1), 32'd1);
      end
      next_cycle();
      in_valid = 1'b0;
    end
    flush(20);

    // Parity for 07 and 03
    in_valid = 1'b1;
    in_data  = 8'h07;
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("p07_load", 32'(load1), 32'd1);
    check_eq("p07_data", 32'(data1), 32'h07);
    check_eq("p07_odd", 32'(par1), 32'd0);
    check_eq("p07_even", 32'(par0), 32'd1);
    next_cycle();
    flush(20);
    in_valid = 1'b1;
    in_data  = 8'h03;
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("p03_odd", 32'(par1), 32'd1);
    check_eq("p03_even", 32'(par0), 32'd0);
    next_cycle();
    flush(20);

    // Streaming without and with the stop gap
    run_stream(1'b0, 13, 13, 25);
    flush(60);
    run_stream(1'b1, 16, 16, 31);
    flush(60);

    // tx_en low: byte parks in the hold register until tx_en rises in cycle 10
    tx_en    = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'h55;
    for (int c = 0; c <= 11; c++) begin
      @(negedge clk);
      if (c == 0) begin
        check_eq("txen_acc0", 32'(rdy0), 32'd1);
        check_eq("txen_acc1", 32'(rdy1), 32'd1);
      end else if (c <= 10) begin
        check_eq("txen_full", 32'(rdy0), 32'd0);
      end
      check_eq("txen_load0", 32'(load0), 32'(c == 11));
      check_eq("txen_load1", 32'(load1), 32'(c == 11));
      if (c == 11) begin
        check_eq("txen_data0", 32'(data0), 32'h55);
        check_eq("txen_data1", 32'(data1), 32'h55);
      end
      next_cycle();
      in_valid = 1'b0;
      if (c + 1 == 10) tx_en = 1'b1;
    end
    flush(20);

    // Reset in the 5th shift cycle drops the frame and the held byte BB
    in_valid = 1'b1;
    in_data  = 8'hAA;
    for (int c = 0; c <= 22; c++) begin
      @(negedge clk);
      if (c < 6) begin
        check_eq("abort_pre", 32'({load0, shift0}), 32'({c == 1, c >= 2}));
      end else if (c == 6) begin
        check_eq("abort_busy", 32'(busy0), 32'd1);
        check_eq("abort_rdy_rst", 32'(rdy0), 32'd0);
      end else if (c == 7) begin
        check_eq("abort_ctrl0", 32'({load0, shift0, busy0, done0}), 32'd0);
        check_eq("abort_ctrl1", 32'({load1, shift1, busy1, done1}), 32'd0);
        check_eq("abort_rdy0", 32'(rdy0), 32'd1);
        check_eq("abort_rdy1", 32'(rdy1), 32'd1);
      end else begin
        check_eq("abort_quiet", 32'({load0, busy0, load1, busy1}), 32'd0);
      end
      next_cycle();
      if (c + 1 == 1) in_data = 8'hBB;
      if (c + 1 == 2) in_valid = 1'b0;
      if (c + 1 == 6) rst = 1'b1;
      if (c + 1 == 7) rst = 1'b0;
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
